// File: rtl/dma_slot_arbiter.sv
// Per-color-clock DMA slot arbiter: fixed refresh/disk/audio/sprite slots,
// bitplane fetch window, copper on even slots, blitter with CPU yield.
module dma_slot_arbiter #(
  parameter logic [7:0] HPOS_LAST = 8'd226
) (
  input  logic       main_clk,
  input  logic       main_rst,
  input  logic       cck_ena,
  input  logic [7:0] hpos,
  input  logic       dma_en,
  input  logic [5:0] ch_en,
  input  logic       dsk_req,
  input  logic [3:0] aud_req,
  input  logic [7:0] spr_req,
  input  logic       bpl_req,
  input  logic       cop_req,
  input  logic       blt_req,
  input  logic       cpu_req,
  input  logic       blit_nasty,
  input  logic [7:0] ddf_start,
  input  logic [7:0] ddf_stop,
  output logic [2:0] owner,
  output logic [2:0] owner_idx,
  output logic       dbr_n
);

  localparam logic [2:0] OWN_CPU = 3'd0;
  localparam logic [2:0] OWN_REF = 3'd1;
  localparam logic [2:0] OWN_DSK = 3'd2;
  localparam logic [2:0] OWN_AUD = 3'd3;
  localparam logic [2:0] OWN_BPL = 3'd4;
  localparam logic [2:0] OWN_SPR = 3'd5;
  localparam logic [2:0] OWN_COP = 3'd6;
  localparam logic [2:0] OWN_BLT = 3'd7;

  logic [2:0] owner_d, owner_q;
  logic [2:0] idx_d, idx_q;
  logic       dbr_n_d, dbr_n_q;
  logic [1:0] blt_run_d, blt_run_q;

  logic       in_range;
  logic       ref_slot, dsk_slot, aud_slot, spr_slot, bpl_win;
  logic       dsk_ok, aud_ok, spr_ok, bpl_ok, cop_ok, blt_ok;
  logic       blt_yield;
  logic [1:0] aud_ch;
  logic [2:0] spr_no;

  always_comb begin
    aud_ch   = 2'((hpos - 8'h0f) >> 1);
    spr_no   = 3'((hpos - 8'h17) >> 2);
    in_range = hpos <= HPOS_LAST;
    ref_slot = hpos inside {8'h01, 8'h03, 8'h05, 8'h07};
    dsk_slot = hpos inside {8'h09, 8'h0b, 8'h0d};
    aud_slot = hpos[0] && hpos >= 8'h0f && hpos <= 8'h15;
    spr_slot = hpos[0] && hpos >= 8'h17 && hpos <= 8'h35;
    // start > stop naturally yields an empty window
    bpl_win  = hpos[0] && hpos >= ddf_start && hpos <= ddf_stop;

    dsk_ok = dsk_slot && dma_en && ch_en[0] && dsk_req;
    aud_ok = aud_slot && dma_en && ch_en[1] && aud_req[aud_ch];
    bpl_ok = bpl_win  && dma_en && ch_en[3] && bpl_req;
    spr_ok = spr_slot && dma_en && ch_en[2] && spr_req[spr_no];
    cop_ok = !hpos[0] && dma_en && ch_en[4] && cop_req;
    blt_ok = dma_en && ch_en[5] && blt_req;
    blt_yield = (blt_run_q == 2'd3) && !blit_nasty && cpu_req;

    owner_d   = owner_q;
    idx_d     = idx_q;
    dbr_n_d   = dbr_n_q;
    blt_run_d = blt_run_q;

    if (cck_ena) begin
      owner_d = OWN_CPU;
      idx_d   = 3'd0;
      if (in_range) begin
        if (ref_slot) begin
          owner_d = OWN_REF;
        end else if (dsk_ok) begin
          owner_d = OWN_DSK;
        end else if (aud_ok) begin
          owner_d = OWN_AUD;
          idx_d   = {1'b0, aud_ch};
        end else if (bpl_ok) begin
          owner_d = OWN_BPL;
        end else if (spr_ok) begin
          owner_d = OWN_SPR;
          idx_d   = spr_no;
        end else if (cop_ok) begin
          owner_d = OWN_COP;
        end else if (blt_ok && !blt_yield) begin
          owner_d = OWN_BLT;
        end

        if (!cpu_req || owner_d == OWN_CPU) begin
          blt_run_d = 2'd0;
        end else if (owner_d == OWN_BLT && blt_run_q != 2'd3) begin
          blt_run_d = blt_run_q + 2'd1;
        end
      end
      dbr_n_d = owner_d == OWN_CPU;
    end
  end

  always_ff @(posedge main_clk) begin
    if (main_rst) begin
      owner_q   <= OWN_CPU;
      idx_q     <= 3'd0;
      dbr_n_q   <= 1'b1;
      blt_run_q <= 2'd0;
    end else begin
      owner_q   <= owner_d;
      idx_q     <= idx_d;
      dbr_n_q   <= dbr_n_d;
      blt_run_q <= blt_run_d;
    end
  end

  assign owner     = owner_q;
  assign owner_idx = idx_q;
  assign dbr_n     = dbr_n_q;

endmodule

// File: tb/tb_dma_slot_arbiter.sv
// Directed-vector bench for dma_slot_arbiter with hand-computed
// slot owners for each scenario.
module tb_dma_slot_arbiter;

  logic       main_clk = 1'b0;
  logic       main_rst;
  logic       cck_ena;
  logic [7:0] hpos;
  logic       dma_en;
  logic [5:0] ch_en;
  logic       dsk_req;
  logic [3:0] aud_req;
  logic [7:0] spr_req;
  logic       bpl_req, cop_req, blt_req, cpu_req, blit_nasty;
  logic [7:0] ddf_start, ddf_stop;
  logic [2:0] owner, owner_idx;
  logic       dbr_n;

  int errors = 0;
  int checks = 0;

  always #5 main_clk = ~main_clk;

  dma_slot_arbiter #(.HPOS_LAST(8'd226)) dut (
    .main_clk(main_clk), .main_rst(main_rst), .cck_ena(cck_ena),
    .hpos(hpos), .dma_en(dma_en), .ch_en(ch_en),
    .dsk_req(dsk_req), .aud_req(aud_req), .spr_req(spr_req),
    .bpl_req(bpl_req), .cop_req(cop_req), .blt_req(blt_req),
    .cpu_req(cpu_req), .blit_nasty(blit_nasty),
    .ddf_start(ddf_start), .ddf_stop(ddf_stop),
    .owner(owner), .owner_idx(owner_idx), .dbr_n(dbr_n)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic slot(input logic [7:0] h);
    @(negedge main_clk);
    hpos    = h;
    cck_ena = 1'b1;
    @(posedge main_clk);
    #1;
    cck_ena = 1'b0;
  endtask

  task automatic exp_slot(input string tag, input logic [7:0] h,
                          input int own, input int idx);
    slot(h);
    chk({tag, ".owner"}, int'(owner), own);
    chk({tag, ".idx"}, int'(owner_idx), idx);
    chk({tag, ".dbr_n"}, int'(dbr_n), (own == 0) ? 1 : 0);
  endtask

  task automatic do_rst();
    @(negedge main_clk);
    main_rst = 1'b1;
    @(posedge main_clk);
    #1;
    main_rst = 1'b0;
  endtask

  task automatic quiet();
    dma_en = 1'b1; ch_en = 6'h3f;
    dsk_req = 1'b0; aud_req = 4'h0; spr_req = 8'h00;
    bpl_req = 1'b0; cop_req = 1'b0; blt_req = 1'b0;
    cpu_req = 1'b0; blit_nasty = 1'b0;
    ddf_start = 8'h1d; ddf_stop = 8'h27;
  endtask

  initial begin
    main_rst = 1'b1; cck_ena = 1'b0; hpos = 8'h00;
    quiet();
    repeat (2) @(posedge main_clk);
    #1;
    chk("rst.owner", int'(owner), 0);
    chk("rst.idx", int'(owner_idx), 0);
    chk("rst.dbr_n", int'(dbr_n), 1);
    main_rst = 1'b0;

    // dma off: only refresh may take the bus
    dma_en = 1'b0; dsk_req = 1'b1; aud_req = 4'hf; spr_req = 8'hff;
    bpl_req = 1'b1; cop_req = 1'b1; blt_req = 1'b1; cpu_req = 1'b1;
    for (int h = 0; h <= 226; h++) begin
      int e;
      e = (h == 1 || h == 3 || h == 5 || h == 7) ? 1 : 0;
      slot(8'(h));
      chk($sformatf("sweep.owner@%0d", h), int'(owner), e);
      chk($sformatf("sweep.dbr_n@%0d", h), int'(dbr_n), 1 - e);
    end

    // everything requesting, cpu idle
    dma_en = 1'b1; cpu_req = 1'b0;
    exp_slot("all.1d", 8'h1d, 4, 0);
    exp_slot("all.19", 8'h19, 5, 0);
    exp_slot("all.11", 8'h11, 3, 1);
    exp_slot("all.0b", 8'h0b, 2, 0);
    exp_slot("all.05", 8'h05, 1, 0);
    exp_slot("all.27", 8'h27, 4, 0);
    exp_slot("all.29", 8'h29, 5, 4);
    exp_slot("all.35", 8'h35, 5, 7);
    exp_slot("all.28", 8'h28, 6, 0);
    aud_req = 4'b1101;
    exp_slot("audoff.11", 8'h11, 7, 0);
    ddf_start = 8'h30; ddf_stop = 8'h20;
    exp_slot("empty.1d", 8'h1d, 5, 1);
    ch_en = 6'b011111;
    exp_slot("noblt.39", 8'h39, 0, 0);

    // outputs hold between slot pulses
    exp_slot("hold.pre", 8'h28, 6, 0);
    @(negedge main_clk); hpos = 8'h0b;
    @(posedge main_clk); #1;
    chk("hold.owner", int'(owner), 6);

    // copper vs blitter
    quiet(); cop_req = 1'b1; blt_req = 1'b1;
    exp_slot("cop.40", 8'h40, 6, 0);
    exp_slot("blt.41", 8'h41, 7, 0);

    // blitter yields every fourth slot to a waiting cpu
    quiet(); blt_req = 1'b1; cpu_req = 1'b1;
    do_rst();
    for (int i = 0; i < 8; i++) begin
      exp_slot($sformatf("yield.%0d", i), 8'(8'h40 + 2 * i),
               (i % 4 == 3) ? 0 : 7, 0);
    end
    blit_nasty = 1'b1;
    for (int i = 0; i < 6; i++)
      exp_slot($sformatf("nasty.%0d", i), 8'(8'h60 + 2 * i), 7, 0);

    // reset mid-grant restarts the run counter
    quiet(); blt_req = 1'b1; cpu_req = 1'b1;
    do_rst();
    exp_slot("rr.a", 8'h40, 7, 0);
    exp_slot("rr.b", 8'h42, 7, 0);
    @(negedge main_clk);
    hpos = 8'h44; cck_ena = 1'b1; main_rst = 1'b1;
    @(posedge main_clk); #1;
    cck_ena = 1'b0; main_rst = 1'b0;
    chk("rr.rst.owner", int'(owner), 0);
    chk("rr.rst.idx", int'(owner_idx), 0);
    chk("rr.rst.dbr_n", int'(dbr_n), 1);
    exp_slot("rr.0", 8'h46, 7, 0);
    exp_slot("rr.1", 8'h48, 7, 0);
    exp_slot("rr.2", 8'h4a, 7, 0);
    exp_slot("rr.3", 8'h4c, 0, 0);

    // out-of-line slot is idle and leaves the run count alone
    do_rst();
    exp_slot("oor.a", 8'h40, 7, 0);
    exp_slot("oor.b", 8'h42, 7, 0);
    exp_slot("oor.e5", 8'he5, 0, 0);
    exp_slot("oor.c", 8'h44, 7, 0);
    exp_slot("oor.d", 8'h46, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
